// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl
//   Downstream dispense sequencer for the vending machine. Queues item and
//   coin requests from the vending FSM and drives the product motor and the
//   coin-eject solenoid one action at a time, each followed by an idle gap.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous, active-high
//   purchase     one-cycle pulse, one item per high cycle
//   cash_return  00 none, 01 one coin, 10 two coins, 11 illegal (flags overflow)
//   motor_en     product motor drive (registered)
//   coin_eject   change solenoid drive (registered)
//   vend_done    one-cycle pulse per completed item (registered)
//   coin_done    one-cycle pulse per completed coin (registered)
//   busy         action in progress or work queued (decoded from registers)
//   vend_pend    items queued, not yet started
//   coin_pend    coins queued, not yet started
//   overflow     sticky: queue saturated or illegal cash_return code
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | nothing running; picks next item, else next coin (one cycle min)
// MOTOR | motor_en high, timer counts MOTOR_CYCLES down to terminal count
// EJECT | coin_eject high, timer counts EJECT_CYCLES down to terminal count
// GAP   | both drives low for GAP_CYCLES, then back to IDLE
module vend_dispense_ctrl #(
  parameter int MOTOR_CYCLES = 8,
  parameter int EJECT_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int QW           = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          purchase,
  input  logic [1:0]    cash_return,
  output logic          motor_en,
  output logic          coin_eject,
  output logic          vend_done,
  output logic          coin_done,
  output logic          busy,
  output logic [QW-1:0] vend_pend,
  output logic [QW-1:0] coin_pend,
  output logic          overflow
);

  localparam int MAX_ME  = (MOTOR_CYCLES > EJECT_CYCLES) ? MOTOR_CYCLES : EJECT_CYCLES;
  localparam int MAX_CYC = (MAX_ME > GAP_CYCLES) ? MAX_ME : GAP_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] MOTOR_LD = TW'(MOTOR_CYCLES);
  localparam logic [TW-1:0] EJECT_LD = TW'(EJECT_CYCLES);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES);
  localparam logic [TW-1:0] TC       = TW'(1);

  // Sums are formed one bit wider so a saturating add can be detected.
  localparam logic [QW:0] PEND_MAX = {1'b0, {QW{1'b1}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOTOR = 2'd1,
    EJECT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          motor_en_q, motor_en_d;
  logic          coin_eject_q, coin_eject_d;
  logic          vend_done_q, vend_done_d;
  logic          coin_done_q, coin_done_d;
  logic          overflow_q, overflow_d;
  logic [QW-1:0] vend_pend_q, vend_pend_d;
  logic [QW-1:0] coin_pend_q, coin_pend_d;

  logic          vend_take;
  logic          coin_take;
  logic [1:0]    coin_add;
  logic [QW:0]   vend_sum;
  logic [QW:0]   coin_sum;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    motor_en_d   = 1'b0;
    coin_eject_d = 1'b0;
    vend_done_d  = 1'b0;
    coin_done_d  = 1'b0;
    vend_take    = 1'b0;
    coin_take    = 1'b0;

    case (state_q)
      IDLE: begin
        // Items always go before coins so change follows its product.
        if (vend_pend_q != '0) begin
          vend_take  = 1'b1;
          state_d    = MOTOR;
          timer_d    = MOTOR_LD;
          motor_en_d = 1'b1;
        end else if (coin_pend_q != '0) begin
          coin_take    = 1'b1;
          state_d      = EJECT;
          timer_d      = EJECT_LD;
          coin_eject_d = 1'b1;
        end
      end
      MOTOR: begin
        if (timer_q == TC) begin
          state_d     = GAP;
          timer_d     = GAP_LD;
          vend_done_d = 1'b1;
        end else begin
          timer_d    = timer_q - TC;
          motor_en_d = 1'b1;
        end
      end
      EJECT: begin
        if (timer_q == TC) begin
          state_d     = GAP;
          timer_d     = GAP_LD;
          coin_done_d = 1'b1;
        end else begin
          timer_d      = timer_q - TC;
          coin_eject_d = 1'b1;
        end
      end
      GAP: begin
        if (timer_q == TC) begin
          state_d = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q - TC;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    coin_add   = 2'd0;
    case (cash_return)
      2'b01:   coin_add = 2'd1;
      2'b10:   coin_add = 2'd2;
      2'b11:   overflow_d = 1'b1;
      default: coin_add = 2'd0;
    endcase

    // A take only happens when the counter is nonzero, so no underflow.
    vend_sum = {1'b0, vend_pend_q} + (QW+1)'(purchase) - (QW+1)'(vend_take);
    coin_sum = {1'b0, coin_pend_q} + (QW+1)'(coin_add) - (QW+1)'(coin_take);

    if (vend_sum > PEND_MAX) begin
      vend_pend_d = '1;
      overflow_d  = 1'b1;
    end else begin
      vend_pend_d = vend_sum[QW-1:0];
    end

    if (coin_sum > PEND_MAX) begin
      coin_pend_d = '1;
      overflow_d  = 1'b1;
    end else begin
      coin_pend_d = coin_sum[QW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      motor_en_q   <= 1'b0;
      coin_eject_q <= 1'b0;
      vend_done_q  <= 1'b0;
      coin_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
      vend_pend_q  <= '0;
      coin_pend_q  <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      motor_en_q   <= motor_en_d;
      coin_eject_q <= coin_eject_d;
      vend_done_q  <= vend_done_d;
      coin_done_q  <= coin_done_d;
      overflow_q   <= overflow_d;
      vend_pend_q  <= vend_pend_d;
      coin_pend_q  <= coin_pend_d;
    end
  end

  assign motor_en   = motor_en_q;
  assign coin_eject = coin_eject_q;
  assign vend_done  = vend_done_q;
  assign coin_done  = coin_done_q;
  assign overflow   = overflow_q;
  assign vend_pend  = vend_pend_q;
  assign coin_pend  = coin_pend_q;
  assign busy       = (state_q != IDLE) | (|vend_pend_q) | (|coin_pend_q);

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
module tb_vend_dispense_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       purchase;
  logic [1:0] cash_return;
  logic       motor_en;
  logic       coin_eject;
  logic       vend_done;
  logic       coin_done;
  logic       busy;
  logic [2:0] vend_pend;
  logic [2:0] coin_pend;
  logic       overflow;

  always #5 clk = ~clk;

  vend_dispense_ctrl #(
    .MOTOR_CYCLES(8),
    .EJECT_CYCLES(4),
    .GAP_CYCLES  (2),
    .QW          (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .purchase   (purchase),
    .cash_return(cash_return),
    .motor_en   (motor_en),
    .coin_eject (coin_eject),
    .vend_done  (vend_done),
    .coin_done  (coin_done),
    .busy       (busy),
    .vend_pend  (vend_pend),
    .coin_pend  (coin_pend),
    .overflow   (overflow)
  );

  int errors = 0;
  int checks = 0;

  // Per-cycle activity statistics, gathered one sample after each edge.
  int   cyc = 0;
  int   motor_hi, eject_hi, motor_bursts, eject_bursts;
  int   vdone_cnt, cdone_cnt, excl_cnt;
  int   min_gap, max_gap, last_act, first_motor, first_eject, peak_vp;
  logic prev_m, prev_e;

  task automatic clear_stats;
    motor_hi = 0; eject_hi = 0; motor_bursts = 0; eject_bursts = 0;
    vdone_cnt = 0; cdone_cnt = 0;
    min_gap = 1000; max_gap = -1; last_act = -1;
    first_motor = -1; first_eject = -1; peak_vp = 0;
    prev_m = motor_en; prev_e = coin_eject;
  endtask

  task automatic tick;
    int g;
    @(posedge clk);
    #1;
    cyc++;
    if (motor_en) begin
      motor_hi++;
      if (first_motor < 0) first_motor = cyc;
      if (!prev_m) motor_bursts++;
    end
    if (coin_eject) begin
      eject_hi++;
      if (first_eject < 0) first_eject = cyc;
      if (!prev_e) eject_bursts++;
    end
    if (motor_en && coin_eject) excl_cnt++;
    if (vend_done) vdone_cnt++;
    if (coin_done) cdone_cnt++;
    if (int'(vend_pend) > peak_vp) peak_vp = int'(vend_pend);
    if (motor_en || coin_eject) begin
      if (!(prev_m || prev_e) && last_act >= 0) begin
        g = cyc - last_act - 1;
        if (g < min_gap) min_gap = g;
        if (g > max_gap) max_gap = g;
      end
      last_act = cyc;
    end
    prev_m = motor_en;
    prev_e = coin_eject;
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if ({motor_en, coin_eject, vend_done, coin_done, overflow} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want 00000",
               {motor_en, coin_eject, vend_done, coin_done, overflow});
    end
    checks++;
    if ({vend_pend, coin_pend} !== 6'b0) begin
      errors++;
      $display("FAIL reset_counters: got vend_pend=%0d coin_pend=%0d, want 0 0", vend_pend, coin_pend);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b, want 0", busy);
    end
  endtask

  task automatic test_single;
    clear_stats();
    purchase = 1'b1;
    tick();                          // E0
    purchase = 1'b0;
    checks++;
    if (vend_pend !== 3'd1 || motor_en !== 1'b0) begin
      errors++;
      $display("FAIL single_e0: got vend_pend=%0d motor_en=%b, want 1 0", vend_pend, motor_en);
    end
    tick();                          // E1
    checks++;
    if (motor_en !== 1'b1 || vend_pend !== 3'd0) begin
      errors++;
      $display("FAIL single_e1: got motor_en=%b vend_pend=%0d, want 1 0", motor_en, vend_pend);
    end
    repeat (7) tick();               // E2..E8
    checks++;
    if (motor_en !== 1'b1 || vend_done !== 1'b0) begin
      errors++;
      $display("FAIL single_last_motor: got motor_en=%b vend_done=%b, want 1 0", motor_en, vend_done);
    end
    tick();                          // E9, first GAP cycle
    checks++;
    if (motor_en !== 1'b0 || vend_done !== 1'b1) begin
      errors++;
      $display("FAIL single_done: got motor_en=%b vend_done=%b, want 0 1", motor_en, vend_done);
    end
    tick();                          // E10, second GAP cycle
    checks++;
    if (vend_done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_gap: got vend_done=%b busy=%b, want 0 1", vend_done, busy);
    end
    tick();                          // E11, back in IDLE
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_drop: got %b, want 0", busy);
    end
    checks++;
    if (motor_hi !== 8 || vdone_cnt !== 1 || eject_hi !== 0) begin
      errors++;
      $display("FAIL single_totals: got motor=%0d vend_done=%0d eject=%0d, want 8 1 0",
               motor_hi, vdone_cnt, eject_hi);
    end
  endtask

  task automatic test_change;
    bit ok;
    clear_stats();
    purchase    = 1'b1;
    cash_return = 2'b01;
    tick();
    purchase    = 1'b0;
    cash_return = 2'b00;
    checks++;
    if (vend_pend !== 3'd1 || coin_pend !== 3'd1) begin
      errors++;
      $display("FAIL change_queue: got vend_pend=%0d coin_pend=%0d, want 1 1", vend_pend, coin_pend);
    end
    wait_idle(100, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL change_timeout: busy still %b after 100 cycles, want 0", busy);
    end
    checks++;
    if (motor_hi !== 8 || eject_hi !== 4 || vdone_cnt !== 1 || cdone_cnt !== 1) begin
      errors++;
      $display("FAIL change_totals: got motor=%0d eject=%0d vdone=%0d cdone=%0d, want 8 4 1 1",
               motor_hi, eject_hi, vdone_cnt, cdone_cnt);
    end
    checks++;
    if (!(first_motor >= 0 && first_eject > first_motor)) begin
      errors++;
      $display("FAIL change_order: got first motor cycle %0d, first eject cycle %0d, want motor first",
               first_motor, first_eject);
    end
    checks++;
    if (min_gap !== 3 || max_gap !== 3) begin
      errors++;
      $display("FAIL change_gap: got min=%0d max=%0d low cycles, want 3 3", min_gap, max_gap);
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    clear_stats();
    purchase = 1'b1;
    repeat (3) tick();
    purchase = 1'b0;
    wait_idle(200, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL b2b_timeout: busy still %b after 200 cycles, want 0", busy);
    end
    checks++;
    if (peak_vp !== 2) begin
      errors++;
      $display("FAIL b2b_peak: got vend_pend peak %0d, want 2", peak_vp);
    end
    checks++;
    if (motor_bursts !== 3 || motor_hi !== 24 || vdone_cnt !== 3) begin
      errors++;
      $display("FAIL b2b_totals: got bursts=%0d motor=%0d vdone=%0d, want 3 24 3",
               motor_bursts, motor_hi, vdone_cnt);
    end
    checks++;
    if (min_gap !== 3 || max_gap !== 3) begin
      errors++;
      $display("FAIL b2b_gap: got min=%0d max=%0d low cycles, want 3 3", min_gap, max_gap);
    end
  endtask

  task automatic test_saturation;
    bit ok;
    apply_reset();
    clear_stats();
    purchase = 1'b1;
    tick();
    purchase = 1'b0;
    tick();
    checks++;
    if (motor_en !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL sat_start: got motor_en=%b overflow=%b, want 1 0", motor_en, overflow);
    end
    purchase = 1'b1;
    repeat (9) tick();
    purchase = 1'b0;
    checks++;
    if (vend_pend !== 3'd7 || overflow !== 1'b1 || peak_vp !== 7) begin
      errors++;
      $display("FAIL sat_clamp: got vend_pend=%0d overflow=%b peak=%0d, want 7 1 7",
               vend_pend, overflow, peak_vp);
    end
    wait_idle(300, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL sat_timeout: busy still %b after 300 cycles, want 0", busy);
    end
    checks++;
    if (motor_bursts !== 8 || vdone_cnt !== 8 || motor_hi !== 64) begin
      errors++;
      $display("FAIL sat_totals: got bursts=%0d vdone=%0d motor=%0d, want 8 8 64",
               motor_bursts, vdone_cnt, motor_hi);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL sat_sticky: got overflow=%b, want 1", overflow);
    end
  endtask

  task automatic test_illegal;
    bit ok;
    apply_reset();
    clear_stats();
    purchase    = 1'b1;
    cash_return = 2'b01;
    tick();
    purchase    = 1'b0;
    cash_return = 2'b00;
    tick();
    checks++;
    if (coin_pend !== 3'd1 || overflow !== 1'b0 || motor_en !== 1'b1) begin
      errors++;
      $display("FAIL illegal_pre: got coin_pend=%0d overflow=%b motor_en=%b, want 1 0 1",
               coin_pend, overflow, motor_en);
    end
    cash_return = 2'b11;
    tick();
    cash_return = 2'b00;
    checks++;
    if (coin_pend !== 3'd1 || overflow !== 1'b1 || coin_eject !== 1'b0) begin
      errors++;
      $display("FAIL illegal_code: got coin_pend=%0d overflow=%b coin_eject=%b, want 1 1 0",
               coin_pend, overflow, coin_eject);
    end
    wait_idle(100, ok);
    checks++;
    if (ok !== 1'b1 || eject_bursts !== 1 || cdone_cnt !== 1) begin
      errors++;
      $display("FAIL illegal_after: got idle=%b eject_bursts=%0d cdone=%0d, want 1 1 1",
               ok, eject_bursts, cdone_cnt);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL illegal_sticky: got overflow=%b, want 1", overflow);
    end
  endtask

  task automatic test_reset_mid;
    apply_reset();
    clear_stats();
    purchase    = 1'b1;
    cash_return = 2'b10;
    tick();                          // E0
    purchase    = 1'b0;
    cash_return = 2'b00;
    checks++;
    if (coin_pend !== 3'd2 || vend_pend !== 3'd1) begin
      errors++;
      $display("FAIL rmid_queue: got vend_pend=%0d coin_pend=%0d, want 1 2", vend_pend, coin_pend);
    end
    repeat (4) tick();               // E1..E4, motor cycles 1..4
    checks++;
    if (motor_en !== 1'b1 || motor_hi !== 4) begin
      errors++;
      $display("FAIL rmid_run: got motor_en=%b motor cycles=%0d, want 1 4", motor_en, motor_hi);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (motor_en !== 1'b0 || vend_pend !== 3'd0 || coin_pend !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_reset: got motor_en=%b vend_pend=%0d coin_pend=%0d busy=%b, want 0 0 0 0",
               motor_en, vend_pend, coin_pend, busy);
    end
    reset = 1'b0;
    clear_stats();
    repeat (30) tick();
    checks++;
    if (motor_hi !== 0 || eject_hi !== 0 || vdone_cnt !== 0 || cdone_cnt !== 0) begin
      errors++;
      $display("FAIL rmid_after: got motor=%0d eject=%0d vdone=%0d cdone=%0d, want 0 0 0 0",
               motor_hi, eject_hi, vdone_cnt, cdone_cnt);
    end
  endtask

  initial begin
    reset       = 1'b1;
    purchase    = 1'b0;
    cash_return = 2'b00;
    excl_cnt    = 0;
    clear_stats();

    test_reset();
    test_single();
    test_change();
    test_back_to_back();
    test_saturation();
    test_illegal();
    test_reset_mid();

    checks++;
    if (excl_cnt !== 0) begin
      errors++;
      $display("FAIL mutual_exclusion: got %0d cycles with both drives high, want 0", excl_cnt);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
